// File: rtl/prng_uart_pkg.sv
// Shared types and default constants for the PRNG-to-UART transmitter slice.
package prng_uart_pkg;

    // UART transmitter states; IDLE must stay the reset encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Default build parameters.
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_SAMPLE_DIV   = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    // 8N1 framing: eight data bits between one start and one stop bit.
    localparam int UART_DATA_BITS   = 8;

endpackage : prng_uart_pkg

// File: rtl/prng_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through read data.
// Push is ignored when full and pop is ignored when empty; fullness is taken
// from the registered count, so a push into a full FIFO is refused even when a
// pop happens in the same cycle.
module prng_byte_fifo
    import prng_uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    // NOTE: the storage array has no reset; the pointers define which entries
    // are valid, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : prng_byte_fifo

// File: rtl/prng_uart_tx.sv
// Samples the free-running generator byte every SAMPLE_DIV enabled clocks,
// queues it in a small FIFO and sends queued bytes as UART 8N1 frames.
// Samples arriving while the FIFO is full are counted in a saturating counter.
module prng_uart_tx
    import prng_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rnd_in,
    input  logic                          en,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    dropped
);

    // A divide-by-one build still needs a one-bit divider register.
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    // Sample divider and drop counter.
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       dropped_q, dropped_d;
    logic             sample_strobe;

    // Transmitter state.
    tx_state_e        state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             pop;
    logic             bit_done;

    // FIFO interface.
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;

    assign sample_strobe = en && (div_q == DIV_LAST);
    assign bit_done      = (tmr_q == TMR_LAST);

    prng_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sample_strobe),
        .pop_i   (pop),
        .data_i  (rnd_in),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Divider restarts from zero whenever sampling is disabled.
    always_comb begin
        div_d = div_q;
        if (!en) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Drop counter advances on a refused sample and sticks at 0xFF.
    always_comb begin
        dropped_d = dropped_q;
        if (sample_strobe && fifo_full && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // Divider and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            dropped_q <= '0;
        end else begin
            div_q     <= div_d;
            dropped_q <= dropped_d;
        end
    end

    // Transmitter next state; tx_d is the line level for the coming cycle,
    // so the registered tx tracks the state without an output decode.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                tmr_d = '0;
                idx_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    tmr_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    tmr_d   = tmr_q + TMR_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    tmr_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    tmr_d = '0;
                    // Chain straight into the next frame when a byte waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tmr_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmitter registers; reset forces the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != IDLE);
    assign dropped = dropped_q;

endmodule : prng_uart_tx
